// File: rtl/seg7_digit_scanner_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment digit scanner.
package seg7_digit_scanner_pkg;

  localparam int BCD_MAX     = 9;
  localparam int DIGIT_W     = 4;
  localparam int MAX_DIGITS  = 8;
  localparam int FRAME_MAX_W = MAX_DIGITS * DIGIT_W;

  typedef logic [DIGIT_W-1:0] bcd_t;

  // Highest index among the first n digits holding a non-zero code; 0 when all are zero.
  function automatic logic [2:0] msnz_index(input logic [FRAME_MAX_W-1:0] frame, input int n);
    logic [2:0] r;
    r = '0;
    for (int k = 0; k < MAX_DIGITS; k++) begin
      if (k < n && frame[k*DIGIT_W +: DIGIT_W] != '0) r = 3'(k);
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_digit_scanner_if.sv
// Frame input and display output bundle between a frame source and the scanner.
interface seg7_digit_scanner_if #(
  parameter int N_DIGITS = 4
);
  import seg7_digit_scanner_pkg::*;

  logic [N_DIGITS*DIGIT_W-1:0] digits_bcd;
  logic [N_DIGITS-1:0]         dp_in;
  logic                        lz_blank;
  logic [DIGIT_W-1:0]          bcd_out;
  logic [N_DIGITS-1:0]         digit_en;
  logic                        dp_out;
  logic                        scan_tick;
  logic                        bad_code;

  modport master (
    output digits_bcd, dp_in, lz_blank,
    input  bcd_out, digit_en, dp_out, scan_tick, bad_code
  );

  modport slave (
    input  digits_bcd, dp_in, lz_blank,
    output bcd_out, digit_en, dp_out, scan_tick, bad_code
  );

endinterface

// File: rtl/seg7_scan_timer.sv
// Slot prescaler and digit index counter; flags slot advance, blank window and frame start.
module seg7_scan_timer #(
  parameter int N_DIGITS     = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  output logic [$clog2(N_DIGITS)-1:0] idx,
  output logic                        tick,
  output logic                        blank,
  output logic                        frame_start
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(N_DIGITS);

  logic [CNT_W-1:0] cnt;
  logic             cnt_last;
  logic             idx_last;

  assign cnt_last    = (cnt == CNT_W'(SCAN_DIV - 1));
  assign idx_last    = (idx == IDX_W'(N_DIGITS - 1));
  assign tick        = en && cnt_last;
  assign blank       = (cnt < CNT_W'(BLANK_CYCLES));
  assign frame_start = (cnt == '0) && (idx == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (en) begin
      if (cnt_last) begin
        cnt <= '0;
        idx <= idx_last ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_digit_scanner.sv
// Time-multiplexed N-digit BCD scanner with blanking gap, leading-zero and invalid-code suppression.
module seg7_digit_scanner
  import seg7_digit_scanner_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  seg7_digit_scanner_if.slave   bus
);

  localparam int IDX_W   = $clog2(N_DIGITS);
  localparam int FRAME_W = N_DIGITS * DIGIT_W;

  logic [IDX_W-1:0] idx;
  logic             tick;
  logic             blank;
  logic             frame_start;

  seg7_scan_timer #(
    .N_DIGITS     (N_DIGITS),
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .idx         (idx),
    .tick        (tick),
    .blank       (blank),
    .frame_start (frame_start)
  );

  logic [FRAME_W-1:0]  snap_digits;
  logic [N_DIGITS-1:0] snap_dp;
  logic                snap_lz;
  logic                take_snap;

  assign take_snap = en && frame_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_digits <= '0;
      snap_dp     <= '0;
      snap_lz     <= 1'b0;
    end else if (take_snap) begin
      snap_digits <= bus.digits_bcd;
      snap_dp     <= bus.dp_in;
      snap_lz     <= bus.lz_blank;
    end
  end

  // Stage p0: digit select and suppression; the live frame is forwarded on the snapshot cycle
  logic [FRAME_W-1:0]  cur_digits;
  logic [N_DIGITS-1:0] cur_dp;
  logic                cur_lz;
  bcd_t                code_p0;
  logic [2:0]          top_idx_p0;
  logic                suppress_p0;
  logic                invalid_p0;
  logic                lit_p0;
  bcd_t                bcd_p0;
  logic [N_DIGITS-1:0] digit_en_p0;
  logic                dp_p0;
  logic                bad_set_p0;

  always_comb begin
    cur_digits  = take_snap ? bus.digits_bcd : snap_digits;
    cur_dp      = take_snap ? bus.dp_in      : snap_dp;
    cur_lz      = take_snap ? bus.lz_blank   : snap_lz;
    code_p0     = cur_digits[idx*DIGIT_W +: DIGIT_W];
    top_idx_p0  = msnz_index(FRAME_MAX_W'(cur_digits), N_DIGITS);
    suppress_p0 = cur_lz && (3'(idx) > top_idx_p0);
    invalid_p0  = (code_p0 > DIGIT_W'(BCD_MAX));
    lit_p0      = en && !blank && !suppress_p0 && !invalid_p0;
    bcd_p0      = invalid_p0 ? '0 : code_p0;
    digit_en_p0 = lit_p0 ? (N_DIGITS'(1) << idx) : '0;
    dp_p0       = lit_p0 && cur_dp[idx];
    bad_set_p0  = en && !blank && !suppress_p0 && invalid_p0;
  end

  // Stage p1: registered display outputs
  bcd_t                bcd_p1;
  logic [N_DIGITS-1:0] digit_en_p1;
  logic                dp_p1;
  logic                tick_p1;
  logic                bad_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_p1      <= '0;
      digit_en_p1 <= '0;
      dp_p1       <= 1'b0;
      tick_p1     <= 1'b0;
      bad_p1      <= 1'b0;
    end else begin
      digit_en_p1 <= digit_en_p0;
      dp_p1       <= dp_p0;
      tick_p1     <= tick;
      if (en)         bcd_p1 <= bcd_p0;
      if (bad_set_p0) bad_p1 <= 1'b1;
    end
  end

  assign bus.bcd_out   = bcd_p1;
  assign bus.digit_en  = digit_en_p1;
  assign bus.dp_out    = dp_p1;
  assign bus.scan_tick = tick_p1;
  assign bus.bad_code  = bad_p1;

endmodule

// File: tb/tb_seg7_digit_scanner.sv
// Randomized self-checking bench for seg7_digit_scanner against a position-based reference model.
module tb_seg7_digit_scanner;

  localparam int N   = 4;
  localparam int DIV = 8;
  localparam int BLK = 2;
  localparam int FRAME = N * DIV;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b0;

  seg7_digit_scanner_if #(.N_DIGITS(N)) bus();

  seg7_digit_scanner #(
    .N_DIGITS     (N),
    .SCAN_DIV     (DIV),
    .BLANK_CYCLES (BLK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: pos counts enabled cycles since reset; slot and phase follow by division.
  int          pos;
  logic [15:0] m_digits;
  logic [3:0]  m_dp;
  logic        m_lz;
  logic [3:0]  e_bcd;
  logic [3:0]  e_en;
  logic        e_dp, e_tick, e_bad;

  task automatic model_reset();
    pos = 0; m_digits = '0; m_dp = '0; m_lz = 1'b0;
    e_bcd = '0; e_en = '0; e_dp = 1'b0; e_tick = 1'b0; e_bad = 1'b0;
  endtask

  task automatic step();
    int phase, slot, top;
    logic [3:0] d;
    logic supp, inval, lit;
    if (en) begin
      phase = pos % DIV;
      slot  = (pos / DIV) % N;
      if (phase == 0 && slot == 0) begin
        m_digits = bus.digits_bcd; m_dp = bus.dp_in; m_lz = bus.lz_blank;
      end
      d = m_digits[slot*4 +: 4];
      top = 0;
      for (int k = 0; k < N; k++) if (m_digits[k*4 +: 4] != 4'd0) top = k;
      supp  = m_lz && (slot > top);
      inval = (d > 4'd9);
      lit   = (phase >= BLK) && !supp && !inval;
      e_en   = lit ? 4'(1 << slot) : 4'd0;
      e_bcd  = inval ? 4'd0 : d;
      e_dp   = lit && m_dp[slot];
      e_tick = (phase == DIV - 1);
      if (phase >= BLK && inval && !supp) e_bad = 1'b1;
      pos++;
    end else begin
      e_en = '0; e_dp = 1'b0; e_tick = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [10:0] act();
    return {bus.bcd_out, bus.digit_en, bus.dp_out, bus.scan_tick, bus.bad_code};
  endfunction

  function automatic logic [10:0] expv();
    return {e_bcd, e_en, e_dp, e_tick, e_bad};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0;
    bus.digits_bcd = '0; bus.dp_in = '0; bus.lz_blank = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (act() !== 11'h0) begin
      failures++; $display("FAIL reset_hold got=%h exp=%h", act(), 11'h0);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (act() !== expv()) begin
      failures++; $display("FAIL reset_idle got=%h exp=%h", act(), expv());
    end
  endtask

  task automatic test_scan_basic();
    int lit_cnt[4];
    int ticks, bad_val;
    ticks = 0; bad_val = 0;
    for (int k = 0; k < 4; k++) lit_cnt[k] = 0;
    bus.digits_bcd = 16'h1234; bus.dp_in = 4'b0101; bus.lz_blank = 1'b0; en = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      checks++;
      if (act() !== expv()) begin
        failures++; $display("FAIL scan_basic pos=%0d got=%h exp=%h", pos, act(), expv());
      end
      for (int k = 0; k < 4; k++) begin
        if (bus.digit_en[k]) begin
          lit_cnt[k]++;
          if (bus.bcd_out !== 4'(4 - k)) bad_val++;
        end
      end
      if (bus.scan_tick) ticks++;
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (lit_cnt[k] != 2 * (DIV - BLK)) begin
        failures++; $display("FAIL scan_lit_time digit=%0d got=%0d exp=%0d", k, lit_cnt[k], 2 * (DIV - BLK));
      end
    end
    checks++;
    if (ticks != 2 * N) begin
      failures++; $display("FAIL scan_tick_count got=%0d exp=%0d", ticks, 2 * N);
    end
    checks++;
    if (bad_val != 0) begin
      failures++; $display("FAIL scan_digit_values got=%0d wrong exp=0", bad_val);
    end
  endtask

  task automatic test_lz_blank();
    logic [3:0] seen;
    seen = '0;
    bus.digits_bcd = 16'h0050; bus.dp_in = 4'b1111; bus.lz_blank = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      step();
      checks++;
      if (act() !== expv()) begin
        failures++; $display("FAIL lz_0050 pos=%0d got=%h exp=%h", pos, act(), expv());
      end
      seen |= bus.digit_en;
    end
    checks++;
    if (seen !== 4'b0011) begin
      failures++; $display("FAIL lz_0050_digits got=%b exp=%b", seen, 4'b0011);
    end
    seen = '0;
    bus.digits_bcd = 16'h0000; bus.dp_in = 4'b0000;
    for (int i = 0; i < FRAME; i++) begin
      step();
      checks++;
      if (act() !== expv()) begin
        failures++; $display("FAIL lz_0000 pos=%0d got=%h exp=%h", pos, act(), expv());
      end
      seen |= bus.digit_en;
      if (bus.digit_en[0] && bus.bcd_out !== 4'd0) seen[3] = 1'b1;
    end
    checks++;
    if (seen !== 4'b0001) begin
      failures++; $display("FAIL lz_0000_digits got=%b exp=%b", seen, 4'b0001);
    end
  endtask

  task automatic test_midframe_change();
    int wrong;
    wrong = 0;
    bus.digits_bcd = 16'h1234; bus.dp_in = '0; bus.lz_blank = 1'b0;
    for (int i = 0; i < FRAME + 2 * DIV; i++) begin
      step();
      checks++;
      if (act() !== expv()) begin
        failures++; $display("FAIL midframe_pre pos=%0d got=%h exp=%h", pos, act(), expv());
      end
    end
    bus.digits_bcd = 16'h5678;
    for (int i = 0; i < 2 * DIV + FRAME; i++) begin
      step();
      checks++;
      if (act() !== expv()) begin
        failures++; $display("FAIL midframe_post pos=%0d got=%h exp=%h", pos, act(), expv());
      end
      if (i < 2 * DIV && bus.digit_en[2] && bus.bcd_out !== 4'd2) wrong++;
      if (i >= 2 * DIV && bus.digit_en[0] && bus.bcd_out !== 4'd8) wrong++;
    end
    checks++;
    if (wrong != 0) begin
      failures++; $display("FAIL midframe_snapshot got=%0d wrong exp=0", wrong);
    end
  endtask

  task automatic test_en_pause();
    int waited;
    logic [3:0] first_en;
    for (int i = 0; i < FRAME && (pos % FRAME) != DIV + 4; i++) begin
      step();
      checks++;
      if (act() !== expv()) begin
        failures++; $display("FAIL pause_align pos=%0d got=%h exp=%h", pos, act(), expv());
      end
    end
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (act() !== expv() || bus.digit_en !== 4'd0 || bus.scan_tick !== 1'b0) begin
        failures++; $display("FAIL pause_hold cyc=%0d got=%h exp=%h", i, act(), expv());
      end
    end
    en = 1'b1;
    waited = 0;
    for (int i = 0; i < DIV && waited == 0; i++) begin
      step();
      checks++;
      if (act() !== expv()) begin
        failures++; $display("FAIL pause_resume pos=%0d got=%h exp=%h", pos, act(), expv());
      end
      if (bus.scan_tick) waited = i + 1;
    end
    checks++;
    if (waited != DIV - 4) begin
      failures++; $display("FAIL pause_remaining got=%0d exp=%0d", waited, DIV - 4);
    end
    first_en = '0;
    for (int i = 0; i < DIV; i++) begin
      step();
      if (first_en == 4'd0) first_en = bus.digit_en;
    end
    checks++;
    if (first_en !== 4'b0100) begin
      failures++; $display("FAIL pause_next_slot got=%b exp=%b", first_en, 4'b0100);
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) == 0) begin
        for (int k = 0; k < N; k++)
          v[k*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 9));
        bus.digits_bcd = v;
        bus.dp_in      = 4'($urandom_range(0, 15));
        bus.lz_blank   = 1'($urandom_range(0, 1));
      end
      step();
      checks++;
      if (act() !== expv()) begin
        failures++; $display("FAIL random pos=%0d got=%h exp=%h", pos, act(), expv());
      end
    end
    en = 1'b1;
  endtask

  task automatic test_bad_code();
    logic lit1;
    lit1 = 1'b0;
    for (int i = 0; i < FRAME && (pos % FRAME) != 0; i++) begin
      step();
      checks++;
      if (act() !== expv()) begin
        failures++; $display("FAIL bad_align pos=%0d got=%h exp=%h", pos, act(), expv());
      end
    end
    bus.digits_bcd = 16'h12C4; bus.dp_in = '0; bus.lz_blank = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      checks++;
      if (act() !== expv()) begin
        failures++; $display("FAIL bad_frame pos=%0d got=%h exp=%h", pos, act(), expv());
      end
      if (bus.digit_en[1]) lit1 = 1'b1;
    end
    checks++;
    if (lit1 !== 1'b0 || bus.bad_code !== 1'b1) begin
      failures++; $display("FAIL bad_flag lit1=%b bad=%b exp lit1=0 bad=1", lit1, bus.bad_code);
    end
    bus.digits_bcd = 16'h1234;
    for (int i = 0; i < FRAME; i++) begin
      step();
      checks++;
      if (act() !== expv() || bus.bad_code !== 1'b1) begin
        failures++; $display("FAIL bad_sticky pos=%0d got=%h exp=%h", pos, act(), expv());
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < FRAME && (pos % FRAME) != 3 * DIV + 4; i++) begin
      step();
      checks++;
      if (act() !== expv()) begin
        failures++; $display("FAIL areset_align pos=%0d got=%h exp=%h", pos, act(), expv());
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (act() !== 11'h0) begin
      failures++; $display("FAIL areset_immediate got=%h exp=%h", act(), 11'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    bus.digits_bcd = 16'h9876; bus.dp_in = 4'b1000; bus.lz_blank = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      checks++;
      if (act() !== expv()) begin
        failures++; $display("FAIL areset_restart pos=%0d got=%h exp=%h", pos, act(), expv());
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_scan_basic();
    test_lz_blank();
    test_midframe_change();
    test_en_pause();
    test_random();
    test_bad_code();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
